// File: rtl/riscv_v_alu_wb_buffer.sv
// Writeback buffer between the vector ALU result bus and the VRF write arbiter.
// Beats are queued in a small FIFO and written to the VRF under a request/grant
// handshake. The buffer reports per-instruction completion with a written-beat
// count and flags a sticky error if the destination register changes
// mid-instruction.
module riscv_v_alu_wb_buffer #(
    parameter int unsigned DATA_WIDTH     = 128,
    parameter int unsigned BE_WIDTH       = DATA_WIDTH / 8,
    parameter int unsigned VD_WIDTH       = 5,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned BEAT_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic [BE_WIDTH-1:0]       in_byte_valid,
    input  logic [VD_WIDTH-1:0]       in_vd,
    input  logic                      in_last,
    input  logic                      flush,
    output logic                      vrf_we,
    input  logic                      vrf_gnt,
    output logic [VD_WIDTH-1:0]       vrf_addr,
    output logic [DATA_WIDTH-1:0]     vrf_wdata,
    output logic [BE_WIDTH-1:0]       vrf_be,
    output logic                      done,
    output logic [BEAT_CNT_WIDTH-1:0] done_beats,
    output logic                      err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = PtrW + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [BE_WIDTH-1:0]   be;
        logic [VD_WIDTH-1:0]   vd;
        logic                  last;
        logic                  marker;
    } entry_t;

    entry_t                    mem_q [DEPTH];
    entry_t                    mem_d [DEPTH];
    logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]           occ_q, occ_d;
    logic [BEAT_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                      done_q, done_d;
    logic [BEAT_CNT_WIDTH-1:0] done_beats_q, done_beats_d;
    logic                      trk_active_q, trk_active_d;
    logic [VD_WIDTH-1:0]       trk_vd_q, trk_vd_d;
    logic                      err_q, err_d;

    logic                      full;
    logic                      empty;
    logic                      accept;
    logic                      push;
    logic                      pop;
    entry_t                    head;
    entry_t                    in_entry;
    logic [BEAT_CNT_WIDTH-1:0] cnt_inc;

    // Handshake, head decode and VRF request; outputs are gated to zero when idle.
    always_comb begin
        full     = (occ_q == OccW'(DEPTH));
        empty    = (occ_q == '0);
        in_ready = !full && !rst;
        // A zero-enable beat completes the handshake; only a last one is kept as a marker.
        accept   = in_valid && in_ready && !flush;
        push     = accept && ((in_byte_valid != '0) || in_last);
        in_entry = '{data: in_data, be: in_byte_valid, vd: in_vd, last: in_last,
                     marker: (in_byte_valid == '0)};
        head     = mem_q[rd_ptr_q];
        vrf_we   = !empty && !head.marker;
        // Markers drain on their own; real beats wait for the grant.
        pop      = !empty && (head.marker || vrf_gnt);
        vrf_addr  = vrf_we ? head.vd   : '0;
        vrf_wdata = vrf_we ? head.data : '0;
        vrf_be    = vrf_we ? head.be   : '0;
    end

    // FIFO storage write.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_entry;
        end
    end

    // Pointers, occupancy, beat counter, completion and vd tracking.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        done_beats_d = '0;
        trk_active_d = trk_active_q;
        trk_vd_d     = trk_vd_q;
        err_d        = err_q;
        cnt_inc      = cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + OccW'(1);
        end else if (!push && pop) begin
            occ_d = occ_q - OccW'(1);
        end

        // Saturating count of beats actually written.
        if (pop && !head.marker && (cnt_q != '1)) begin
            cnt_inc = cnt_q + BEAT_CNT_WIDTH'(1);
        end
        cnt_d = cnt_inc;
        if (pop && head.last) begin
            done_d       = 1'b1;
            done_beats_d = cnt_inc;
            cnt_d        = '0;
        end

        // The first accepted beat of an instruction fixes its destination register.
        if (accept) begin
            if (trk_active_q && (in_vd != trk_vd_q)) begin
                err_d = 1'b1;
            end
            if (!trk_active_q) begin
                trk_vd_d = in_vd;
            end
            trk_active_d = !in_last;
        end

        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            occ_d        = '0;
            cnt_d        = '0;
            done_d       = 1'b0;
            done_beats_d = '0;
            trk_active_d = 1'b0;
            trk_vd_d     = '0;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            done_beats_q <= '0;
            trk_active_q <= 1'b0;
            trk_vd_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            done_beats_q <= done_beats_d;
            trk_active_q <= trk_active_d;
            trk_vd_q     <= trk_vd_d;
            err_q        <= err_d;
        end
    end

    // Entry payload needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign done       = done_q;
    assign done_beats = done_beats_q;
    assign err        = err_q;

endmodule

// File: tb/tb_riscv_v_alu_wb_buffer.sv
// Directed bench for riscv_v_alu_wb_buffer: a per-cycle vector table plus
// hand-written sequences for backpressure, flush and mid-stream reset.
module tb_riscv_v_alu_wb_buffer;

    localparam int DW  = 128;
    localparam int BEW = DW / 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [DW-1:0]  in_data = '0;
    logic [BEW-1:0] in_byte_valid = '0;
    logic [4:0]     in_vd = '0;
    logic           in_last = 1'b0;
    logic           flush = 1'b0;
    logic           vrf_we;
    logic           vrf_gnt = 1'b0;
    logic [4:0]     vrf_addr;
    logic [DW-1:0]  vrf_wdata;
    logic [BEW-1:0] vrf_be;
    logic           done;
    logic [7:0]     done_beats;
    logic           err;

    int n_pass  = 0;
    int n_total = 0;

    riscv_v_alu_wb_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_byte_valid(in_byte_valid),
        .in_vd        (in_vd),
        .in_last      (in_last),
        .flush        (flush),
        .vrf_we       (vrf_we),
        .vrf_gnt      (vrf_gnt),
        .vrf_addr     (vrf_addr),
        .vrf_wdata    (vrf_wdata),
        .vrf_be       (vrf_be),
        .done         (done),
        .done_beats   (done_beats),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [15:0] be;
        logic [4:0]  vd;
        logic        last;
        logic        gnt;
        logic        flush;
        logic [7:0]  tag;
        logic        e_ready;
        logic        e_we;
        logic [15:0] e_be;
        logic [4:0]  e_addr;
        logic [7:0]  e_tag;
        logic        e_done;
        logic [7:0]  e_beats;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic v, logic [15:0] be, logic [4:0] vd, logic l,
                                logic g, logic f, logic [7:0] tag, logic e_rdy, logic e_we,
                                logic [15:0] e_be, logic [4:0] e_addr, logic [7:0] e_tag,
                                logic e_done, logic [7:0] e_beats, logic e_err);
        vec_t x;
        x.rst = r; x.valid = v; x.be = be; x.vd = vd; x.last = l; x.gnt = g; x.flush = f;
        x.tag = tag; x.e_ready = e_rdy; x.e_we = e_we; x.e_be = e_be; x.e_addr = e_addr;
        x.e_tag = e_tag; x.e_done = e_done; x.e_beats = e_beats; x.e_err = e_err;
        return x;
    endfunction

    function automatic logic [DW-1:0] wd(logic [7:0] tag);
        return {BEW{tag}};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge and settle before sampling.
    task automatic drive(input logic v, input logic [15:0] be, input logic [4:0] vd,
                         input logic l, input logic g, input logic f, input logic [7:0] tag);
        @(negedge clk);
        in_valid = v; in_byte_valid = be; in_vd = vd; in_last = l;
        vrf_gnt = g; flush = f; in_data = wd(tag);
        #1;
    endtask

    initial begin
        // reset and idle
        tbl.push_back(mk(1,0,16'h0,0,0,0,0,8'h0,   0,0,16'h0,0,8'h0,0,0,0));
        tbl.push_back(mk(0,0,16'h0,0,0,0,0,8'h0,   1,0,16'h0,0,8'h0,0,0,0));
        // streaming, vd=7
        tbl.push_back(mk(0,1,16'hFFFF,7,0,1,0,8'h01, 1,0,16'h0,0,8'h00,0,0,0));
        tbl.push_back(mk(0,1,16'hFFFF,7,0,1,0,8'h02, 1,1,16'hFFFF,7,8'h01,0,0,0));
        tbl.push_back(mk(0,1,16'hFFFF,7,1,1,0,8'h03, 1,1,16'hFFFF,7,8'h02,0,0,0));
        tbl.push_back(mk(0,0,16'h0,0,0,1,0,8'h00,    1,1,16'hFFFF,7,8'h03,0,0,0));
        tbl.push_back(mk(0,0,16'h0,0,0,1,0,8'h00,    1,0,16'h0,0,8'h00,1,3,0));
        tbl.push_back(mk(0,0,16'h0,0,0,1,0,8'h00,    1,0,16'h0,0,8'h00,0,0,0));
        // zero-enable beats, vd=2
        tbl.push_back(mk(0,1,16'h00FF,2,0,1,0,8'h11, 1,0,16'h0,0,8'h00,0,0,0));
        tbl.push_back(mk(0,1,16'h0000,2,0,1,0,8'h22, 1,1,16'h00FF,2,8'h11,0,0,0));
        tbl.push_back(mk(0,1,16'h0000,2,1,1,0,8'h33, 1,0,16'h0,0,8'h00,0,0,0));
        tbl.push_back(mk(0,0,16'h0,0,0,1,0,8'h00,    1,0,16'h0,0,8'h00,0,0,0));
        tbl.push_back(mk(0,0,16'h0,0,0,1,0,8'h00,    1,0,16'h0,0,8'h00,1,1,0));
        tbl.push_back(mk(0,0,16'h0,0,0,1,0,8'h00,    1,0,16'h0,0,8'h00,0,0,0));
        // protocol error: vd 3 then 4, then a clean instruction on vd 5
        tbl.push_back(mk(0,1,16'hFFFF,3,0,1,0,8'h41, 1,0,16'h0,0,8'h00,0,0,0));
        tbl.push_back(mk(0,1,16'hFFFF,4,0,1,0,8'h42, 1,1,16'hFFFF,3,8'h41,0,0,0));
        tbl.push_back(mk(0,0,16'h0,0,0,1,0,8'h00,    1,1,16'hFFFF,4,8'h42,0,0,1));
        tbl.push_back(mk(0,1,16'hFFFF,4,1,1,0,8'h43, 1,0,16'h0,0,8'h00,0,0,1));
        tbl.push_back(mk(0,0,16'h0,0,0,1,0,8'h00,    1,1,16'hFFFF,4,8'h43,0,0,1));
        tbl.push_back(mk(0,1,16'hFFFF,5,1,1,0,8'h44, 1,0,16'h0,0,8'h00,1,3,1));
        tbl.push_back(mk(0,0,16'h0,0,0,1,0,8'h00,    1,1,16'hFFFF,5,8'h44,0,0,1));
        tbl.push_back(mk(0,0,16'h0,0,0,1,0,8'h00,    1,0,16'h0,0,8'h00,1,1,1));
        tbl.push_back(mk(0,0,16'h0,0,0,1,0,8'h00,    1,0,16'h0,0,8'h00,0,0,1));

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            @(negedge clk);
            rst = v.rst; in_valid = v.valid; in_byte_valid = v.be; in_vd = v.vd;
            in_last = v.last; vrf_gnt = v.gnt; flush = v.flush; in_data = wd(v.tag);
            #1;
            check($sformatf("vec%0d", i),
                  256'({in_ready, vrf_we, vrf_be, vrf_addr, done, done_beats, err, vrf_wdata}),
                  256'({v.e_ready, v.e_we, v.e_be, v.e_addr, v.e_done, v.e_beats, v.e_err,
                        (v.e_we ? wd(v.e_tag) : {DW{1'b0}})}));
        end

        // Backpressure: five beats into four entries with no grant.
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'hFFFF, 9, 0, 0, 0, 8'h51 + 8'(i));
            check($sformatf("bp_ready%0d", i), 256'(in_ready), 256'(1'b1));
        end
        drive(1, 16'hFFFF, 9, 1, 0, 0, 8'h55);
        check("bp_full_ready", 256'(in_ready), 256'(1'b0));
        check("bp_hold0", 256'({vrf_we, vrf_addr, vrf_wdata}), 256'({1'b1, 5'd9, wd(8'h51)}));
        drive(1, 16'hFFFF, 9, 1, 0, 0, 8'h55);
        check("bp_hold1", 256'({in_ready, vrf_we, vrf_wdata}), 256'({1'b0, 1'b1, wd(8'h51)}));
        drive(1, 16'hFFFF, 9, 1, 1, 0, 8'h55);
        check("bp_nobypass", 256'({in_ready, vrf_we, vrf_wdata}), 256'({1'b0, 1'b1, wd(8'h51)}));
        drive(1, 16'hFFFF, 9, 1, 1, 0, 8'h55);
        check("bp_accept5", 256'({in_ready, vrf_we, vrf_wdata}), 256'({1'b1, 1'b1, wd(8'h52)}));
        for (int i = 0; i < 3; i++) begin
            drive(0, 16'h0, 0, 0, 1, 0, 8'h00);
            check($sformatf("bp_write%0d", i + 3), 256'({vrf_we, vrf_wdata}),
                  256'({1'b1, wd(8'h53 + 8'(i))}));
        end
        drive(0, 16'h0, 0, 0, 1, 0, 8'h00);
        check("bp_done", 256'({vrf_we, done, done_beats}), 256'({1'b0, 1'b1, 8'd5}));

        // Flush with three queued entries after one beat of the instruction was written.
        drive(1, 16'hFFFF, 10, 0, 0, 0, 8'h61);
        drive(1, 16'hFFFF, 10, 0, 1, 0, 8'h62);
        check("fl_pre_write", 256'({vrf_we, vrf_wdata}), 256'({1'b1, wd(8'h61)}));
        drive(1, 16'hFFFF, 10, 0, 0, 0, 8'h63);
        drive(1, 16'hFFFF, 10, 0, 0, 0, 8'h64);
        drive(1, 16'hFFFF, 10, 1, 1, 1, 8'h65);
        check("fl_cycle", 256'({vrf_we, vrf_wdata}), 256'({1'b1, wd(8'h62)}));
        drive(0, 16'h0, 0, 0, 1, 0, 8'h00);
        check("fl_after", 256'({in_ready, vrf_we, done, err}), 256'({1'b1, 1'b0, 1'b0, 1'b1}));
        drive(1, 16'hFFFF, 11, 0, 1, 0, 8'h71);
        check("fl_no_done", 256'({vrf_we, done}), 256'({1'b0, 1'b0}));
        drive(1, 16'hFFFF, 11, 1, 1, 0, 8'h72);
        check("fl_new0", 256'({vrf_we, vrf_addr, vrf_wdata}), 256'({1'b1, 5'd11, wd(8'h71)}));
        drive(0, 16'h0, 0, 0, 1, 0, 8'h00);
        check("fl_new1", 256'({vrf_we, vrf_wdata}), 256'({1'b1, wd(8'h72)}));
        drive(0, 16'h0, 0, 0, 1, 0, 8'h00);
        check("fl_new_done", 256'({done, done_beats}), 256'({1'b1, 8'd2}));

        // Reset with two entries queued and no grant.
        drive(1, 16'hFFFF, 12, 0, 0, 0, 8'h81);
        drive(1, 16'hFFFF, 12, 1, 0, 0, 8'h82);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; vrf_gnt = 1'b0; in_last = 1'b0;
        #1;
        check("rst_ready_low", 256'({in_ready, vrf_we}), 256'({1'b0, 1'b1}));
        @(negedge clk);
        #1;
        check("rst_values", 256'({in_ready, vrf_we, vrf_addr, vrf_be, done, done_beats, err,
                                  vrf_wdata}), 256'(0));
        @(negedge clk);
        rst = 1'b0; vrf_gnt = 1'b1;
        #1;
        check("rst_release", 256'({in_ready, vrf_we, err}), 256'({1'b1, 1'b0, 1'b0}));
        for (int i = 0; i < 3; i++) begin
            drive(0, 16'h0, 0, 0, 1, 0, 8'h00);
            check($sformatf("rst_quiet%0d", i), 256'({vrf_we, done}), 256'({1'b0, 1'b0}));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/riscv_v_alu_wb_buffer.md
# riscv_v_alu_wb_buffer

Writeback buffer on the consumer side of the vector ALU result interface. It accepts per-beat ALU results (data plus per-byte valid), queues them in a small FIFO, and drives the vector register file (VRF) write port with a request/grant handshake. It reports instruction completion and a sticky protocol error. It sits between the vector ALU result bus and the VRF write arbiter.

## Interface
- DATA_WIDTH, 128, beat width in bits; multiple of 8.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width (derived).
- VD_WIDTH, 5, destination vector register index width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- BEAT_CNT_WIDTH, 8, width of the per-instruction written-beat counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  ALU result beat present.
- in_ready  out  1  buffer can accept a beat this cycle.
- in_data  in  DATA_WIDTH  ALU result data.
- in_byte_valid  in  BE_WIDTH  per-byte valid from the ALU result.
- in_vd  in  VD_WIDTH  destination register.
- in_last  in  1  final beat of the instruction.
- flush  in  1  discard all queued beats and the in-flight instruction state.
- vrf_we  out  1  write request.
- vrf_gnt  in  1  write grant from the VRF arbiter.
- vrf_addr  out  VD_WIDTH  write register.
- vrf_wdata  out  DATA_WIDTH  write data.
- vrf_be  out  BE_WIDTH  write byte enables.
- done  out  1  one-cycle pulse when an instruction's last entry leaves the FIFO.
- done_beats  out  BEAT_CNT_WIDTH  beats actually written for that instruction; valid while done=1.
- err  out  1  sticky: in_vd changed mid-instruction; cleared only by rst.

## Operation
- Push happens when in_valid && in_ready. in_ready = !full && !rst. No full-bypass: a full buffer stays not-ready even if a pop occurs in the same cycle.
- Each entry holds {data, be, vd, last, marker}.
- A beat with in_byte_valid == 0 and in_last == 0 is accepted (handshake completes) but is not enqueued.
- A beat with in_byte_valid == 0 and in_last == 1 is enqueued as a marker entry (marker = 1).
- Head, non-marker entry: vrf_we = 1; vrf_addr/wdata/be come from the head entry. It pops on vrf_we && vrf_gnt.
  - Outputs hold stable while vrf_we = 1 and vrf_gnt = 0.
- Head, marker entry: vrf_we = 0. It pops unconditionally in the cycle it reaches the head.
- Beat counter increments on each non-marker pop.
- When a popped entry has last = 1:
  - next cycle: done = 1 and done_beats = the count including that pop;
  - the counter clears for the next instruction.
- Counter saturates at its maximum; it does not wrap.
- Protocol check: a register holds the vd of the first accepted beat of the current instruction (push side). err sets if a later accepted beat before last carries a different vd. Data still flows normally.
- flush has the highest priority. Same cycle it:
  - empties the FIFO and drops any push;
  - clears the beat counter and the vd tracker;
  - suppresses done.
  - vrf_we is 0 in the following cycle. err is kept.
- Simultaneous push and pop (not full): occupancy stays unchanged; FIFO order is preserved.
- Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits; full when it equals DEPTH, empty when 0.

## Timing
- Reset values: in_ready=0 while rst is high, then 1 the cycle after; vrf_we=0, vrf_addr=0, vrf_wdata=0, vrf_be=0, done=0, done_beats=0, err=0. FIFO empty.
- Latency: a beat accepted at edge N drives vrf_we=1 in cycle N+1 (registered storage, no input-to-output combinational path).
- vrf_* outputs come from registers or the FIFO head; none depends combinationally on in_*.
- Throughput: one beat per cycle with vrf_gnt held at 1.
- done follows the last pop by exactly one cycle.
- Reset mid-operation: all state is discarded at the next edge; no done is issued.

## Test plan
- Streaming: 3 beats to vd=7 with be=0xFFFF, last on beat 3, vrf_gnt=1 -> three writes in consecutive cycles starting 1 cycle after the first accept; done=1 with done_beats=3, 1 cycle after the third write.
- Backpressure: vrf_gnt=0 while pushing 5 beats into DEPTH=4 -> in_ready drops after 4 accepts; vrf_* held stable; after vrf_gnt=1, in order: 4 writes, then the 5th beat accepted and written.
- Zero-enable beats: beats be=0x00FF, be=0x0000 (not last), be=0x0000 (last) -> exactly 1 VRF write (be=0x00FF); done with done_beats=1.
- Protocol error: beat 1 vd=3, beat 2 vd=4 (not last) -> err=1 from the cycle after beat 2 is accepted; both beats are written; err stays 1 across the next instruction until rst.
- Flush: 3 queued entries, flush=1 for one cycle -> vrf_we=0 from the next cycle; no done; a new instruction afterwards reports done_beats counting only its own beats.
- Reset mid-stream: rst asserted with 2 entries queued and vrf_gnt=0 -> all outputs return to their reset values; no write or done is issued after reset is released.
